// File: rtl/mips_data_mem_arbiter.sv
// rtl/mips_data_mem_arbiter.sv - two-port arbiter for the single-port MIPS data memory
// Latches one winner per transaction, drives the memory for one SERVE cycle, then acks.
module mips_data_mem_arbiter #(
    parameter int Data_Width          = 32,
    parameter int Data_Mem_Addr_Width = 8,
    parameter bit Fixed_Priority      = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0,
    input  logic                           req1,
    input  logic                           we0,
    input  logic                           we1,
    input  logic [Data_Mem_Addr_Width-1:0] addr0,
    input  logic [Data_Mem_Addr_Width-1:0] addr1,
    input  logic [Data_Width-1:0]          wdata0,
    input  logic [Data_Width-1:0]          wdata1,
    output logic                           ack0,
    output logic                           ack1,
    output logic [Data_Width-1:0]          rdata,
    output logic                           busy,
    output logic                           mem_we,
    output logic [Data_Mem_Addr_Width-1:0] mem_addr,
    output logic [Data_Width-1:0]          mem_wdata,
    input  logic [Data_Width-1:0]          mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic                           lat_we_q, lat_we_d;
    logic [Data_Mem_Addr_Width-1:0] lat_addr_q, lat_addr_d;
    logic [Data_Width-1:0]          lat_wdata_q, lat_wdata_d;
    logic                           last_grant_q, last_grant_d;
    logic                           ack0_q, ack0_d;
    logic                           ack1_q, ack1_d;
    logic [Data_Width-1:0]          rdata_q, rdata_d;
    logic                           grant;

    always_comb begin
        state_d      = state_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata_d      = rdata_q;
        grant        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port not granted last wins, unless port 0 is fixed-priority
                    if (req0 && req1) grant = Fixed_Priority ? 1'b0 : ~last_grant_q;
                    else              grant = req1;
                    lat_we_d     = grant ? we1    : we0;
                    lat_addr_d   = grant ? addr1  : addr0;
                    lat_wdata_d  = grant ? wdata1 : wdata0;
                    last_grant_d = grant;
                    state_d      = SERVE;
                end
            end
            SERVE: begin
                // last_grant_q holds the port being served for the whole transaction
                if (!lat_we_q) rdata_d = mem_rdata;
                ack0_d  = ~last_grant_q;
                ack1_d  = last_grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata_q      <= rdata_d;
        end
    end

    assign busy      = (state_q == SERVE);
    assign mem_we    = (state_q == SERVE) & lat_we_q;
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// tb/tb_mips_data_mem_arbiter.sv - self-checking bench for mips_data_mem_arbiter
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_mips_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic [31:0] mem [256];
    logic        tb_ld = 1'b0;
    logic [7:0]  tb_ld_addr = '0;
    logic [31:0] tb_ld_data = '0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mips_data_mem_arbiter #(
        .Data_Width(32), .Data_Mem_Addr_Width(8), .Fixed_Priority(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (tb_ld) mem[tb_ld_addr] <= tb_ld_data;
    end

    task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
        tb_ld = 1'b1; tb_ld_addr = a; tb_ld_data = d;
        @(posedge clk);
        #1 tb_ld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ack0 !== 1'b0) $display("FAIL rst_ack0 got %0b want 0", ack0); else passes++;
        checks++; if (ack1 !== 1'b0) $display("FAIL rst_ack1 got %0b want 0", ack1); else passes++;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %0b want 0", mem_we); else passes++;
        checks++; if (mem_addr !== 8'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passes++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0)
                $display("FAIL idle cycle %0d got we=%0b busy=%0b ack0=%0b ack1=%0b want all 0", k, mem_we, busy, ack0, ack1);
            else passes++;
        end
    endtask

    task automatic test_single_read();
        mem_load(8'h10, 32'hDEADBEEF);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL rd_busy got %0b want 1", busy); else passes++;
        checks++; if (ack0 !== 1'b0) $display("FAIL rd_early_ack got %0b want 0", ack0); else passes++;
        checks++; if (mem_addr !== 8'h10) $display("FAIL rd_mem_addr got %h want 10", mem_addr); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we got %0b want 0", mem_we); else passes++;
        @(negedge clk);
        checks++; if (ack0 !== 1'b1) $display("FAIL rd_ack0 got %0b want 1", ack0); else passes++;
        checks++; if (ack1 !== 1'b0) $display("FAIL rd_ack1 got %0b want 0", ack1); else passes++;
        checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata got %h want deadbeef", rdata); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rd_busy_ack got %0b want 0", busy); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (ack0 !== 1'b0) $display("FAIL rd_ack0_pulse got %0b want 0", ack0); else passes++;
    endtask

    task automatic test_write_then_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 32'h12345678;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we got %0b want 1", mem_we); else passes++;
        checks++; if (mem_wdata !== 32'h12345678) $display("FAIL wr_mem_wdata got %h want 12345678", mem_wdata); else passes++;
        @(negedge clk);
        checks++; if (ack1 !== 1'b1) $display("FAIL wr_ack1 got %0b want 1", ack1); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL wr_mem_we_off got %0b want 0", mem_we); else passes++;
        checks++; if (mem[8'h20] !== 32'h12345678) $display("FAIL wr_mem got %h want 12345678", mem[8'h20]); else passes++;
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) $display("FAIL raw_mem_we got %0b want 0", mem_we); else passes++;
        @(negedge clk);
        checks++; if (ack0 !== 1'b1) $display("FAIL raw_ack0 got %0b want 1", ack0); else passes++;
        checks++; if (rdata !== 32'h12345678) $display("FAIL raw_rdata got %h want 12345678", rdata); else passes++;
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        mem_load(8'h40, 32'hAAAA0000);
        mem_load(8'h41, 32'hBBBB1111);
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h41;
        for (int k = 1; k <= 8; k++) begin
            logic e0, e1;
            @(negedge clk);
            e0 = (k == 2 || k == 6);
            e1 = (k == 4 || k == 8);
            checks++;
            if (ack0 !== e0 || ack1 !== e1)
                $display("FAIL rr cycle %0d got ack0=%0b ack1=%0b want ack0=%0b ack1=%0b", k, ack0, ack1, e0, e1);
            else passes++;
            if (e0) begin checks++; if (rdata !== 32'hAAAA0000) $display("FAIL rr_rdata0 got %h want aaaa0000", rdata); else passes++; end
            if (e1) begin checks++; if (rdata !== 32'hBBBB1111) $display("FAIL rr_rdata1 got %h want bbbb1111", rdata); else passes++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) $display("FAIL rr_tail got ack0=%0b ack1=%0b want 0", ack0, ack1); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h0000_1111; vals[1] = 32'h2222_3333; vals[2] = 32'h4444_5555;
        for (int i = 0; i < 3; i++) mem_load(8'(i), vals[i]);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== ((k % 2) == 0)) $display("FAIL b2b cycle %0d ack0 got %0b want %0b", k, ack0, (k % 2) == 0);
            else passes++;
            if ((k % 2) == 0) begin
                checks++;
                if (rdata !== vals[k/2-1]) $display("FAIL b2b_rdata %0d got %h want %h", k/2-1, rdata, vals[k/2-1]);
                else passes++;
                if (k < 6) addr0 = 8'(k/2);
                else req0 = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_serve();
        mem_load(8'h30, 32'h0000AAAA);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 32'h00005555;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) $display("FAIL rs_serve_we got %0b want 1", mem_we); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) $display("FAIL rs_mem_we got %0b want 0", mem_we); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rs_busy got %0b want 0", busy); else passes++;
        checks++; if (rdata !== 32'h0 || mem_addr !== 8'h0) $display("FAIL rs_regs got rdata=%h addr=%h want 0", rdata, mem_addr); else passes++;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem[8'h30] !== 32'h0000AAAA) $display("FAIL rs_mem got %h want 0000aaaa", mem[8'h30]); else passes++;
        checks++; if (ack1 !== 1'b0) $display("FAIL rs_ack1 got %0b want 0", ack1); else passes++;
        @(negedge clk);
        checks++; if (ack1 !== 1'b0 || ack0 !== 1'b0) $display("FAIL rs_ack_late got ack0=%0b ack1=%0b want 0", ack0, ack1); else passes++;
    endtask

    // Reference model: transactions are served one at a time against a shadow array.
    task automatic test_random();
        logic [31:0] shadow [16];
        logic        pend [2];
        logic        p_we [2];
        logic [7:0]  p_addr [2];
        logic [31:0] p_wdata [2];
        int          cnt, exp_port, mlast, nacks;
        logic        exp_we, acking;
        logic [7:0]  exp_addr;
        logic [31:0] exp_rdata;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            mem_load(8'(i), shadow[i]);
        end
        do_reset();
        cnt = 0; mlast = 1; exp_rdata = 32'h0; exp_port = 0; exp_we = 1'b0; exp_addr = '0; nacks = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic e0, e1, ebusy, ewe;
            e0 = (cnt == 1) && (exp_port == 0);
            e1 = (cnt == 1) && (exp_port == 1);
            ebusy = (cnt == 2);
            ewe = (cnt == 2) && exp_we;
            checks++;
            if (ack0 !== e0 || ack1 !== e1 || busy !== ebusy || mem_we !== ewe)
                $display("FAIL rand cycle %0d got ack0=%0b ack1=%0b busy=%0b we=%0b want %0b %0b %0b %0b",
                         cyc, ack0, ack1, busy, mem_we, e0, e1, ebusy, ewe);
            else passes++;
            checks++;
            if (rdata !== exp_rdata) $display("FAIL rand_rdata cycle %0d got %h want %h", cyc, rdata, exp_rdata);
            else passes++;
            if (cnt == 2) begin
                checks++;
                if (mem_addr !== exp_addr) $display("FAIL rand_addr cycle %0d got %h want %h", cyc, mem_addr, exp_addr);
                else passes++;
            end
            acking = (cnt == 1);
            if (acking) nacks++;
            if (cnt > 0) cnt--;
            for (int p = 0; p < 2; p++) begin
                logic issue;
                if (acking && exp_port == p) issue = ($urandom_range(0, 1) == 1);
                else if (!pend[p]) issue = ($urandom_range(0, 3) == 0);
                else issue = 1'b0;
                if (acking && exp_port == p) pend[p] = 1'b0;
                if (issue) begin
                    pend[p] = 1'b1;
                    p_we[p] = ($urandom_range(0, 2) == 0);
                    p_addr[p] = 8'($urandom_range(0, 15));
                    p_wdata[p] = $urandom;
                end
            end
            req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
            req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
            if (cnt == 0 && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) exp_port = (mlast == 1) ? 0 : 1;
                else exp_port = pend[1] ? 1 : 0;
                mlast = exp_port;
                exp_we = p_we[exp_port];
                exp_addr = p_addr[exp_port];
                if (exp_we) shadow[exp_addr[3:0]] = p_wdata[exp_port];
                cnt = 3;
            end
            // cnt is consumed next cycle; 3 marks the SERVE cycle after the next decrement point
            if (cnt == 3) cnt = 2;
            @(negedge clk);
            if (cnt == 1 && !exp_we) exp_rdata = shadow[exp_addr[3:0]];
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (nacks < 50) $display("FAIL rand_activity got %0d acks want at least 50", nacks); else passes++;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_read();
        test_write_then_read();
        test_round_robin();
        test_back_to_back();
        test_reset_in_serve();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
